// File: rtl/instr_fetch_decode_if.sv
// Bus bundle between the fetch/decode front end, instruction memory and the control unit.
// master = fetch/decode stage, slave = memory/control-unit side.
interface instr_fetch_decode_if #(
   parameter int AW = 8,
   parameter int IW = 9,
   parameter int DW = 8
) ();
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          stall;
   logic          pc_mux;
   logic          pc_we;
   logic [26:0]   opcode;
   logic [DW-1:0] imm;
   logic          issue_valid;
   logic [AW-1:0] pc_out;
   logic          illegal;

   modport master (
      output imem_en, imem_addr, opcode, imm, issue_valid, pc_out, illegal,
      input  imem_rdata, stall, pc_mux, pc_we
   );

   modport slave (
      input  imem_en, imem_addr, opcode, imm, issue_valid, pc_out, illegal,
      output imem_rdata, stall, pc_mux, pc_we
   );
endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end: fetches a word (plus optional immediate),
// decodes it to the control unit's {x, y, one-hot op} bundle and owns the PC.
//
// state  | meaning
// FETCH  | read instruction word at pc
// DECODE | latch IR; read immediate at pc+1 if the opcode carries one
// IMM    | latch immediate word
// ISSUE  | present opcode/imm; hold while stalled, update pc on exit
module instr_fetch_decode #(
   parameter int            AW       = 8,
   parameter int            IW       = 9,
   parameter int            DW       = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input logic                   clk,
   input logic                   rst,
   instr_fetch_decode_if.master  bus
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      IMM    = 2'd2,
      ISSUE  = 2'd3
   } state_t;

   state_t        state;
   logic [IW-1:0] ir;
   logic [DW-1:0] imm_q;
   logic [AW-1:0] pc;
   logic [26:0]   opcode_q;
   logic          issue_q;
   logic          illegal_q;
   logic [4:0]    rdata_idx;
   logic [4:0]    ir_idx;

   function automatic logic [22:0] decode_op(input logic [4:0] idx);
      logic [22:0] op;
      op = '0;
      if (idx >= 5'd1 && idx <= 5'd22)
         op = 23'(1) << (idx - 5'd1);
      return op;
   endfunction

   function automatic logic has_imm(input logic [4:0] idx);
      logic r;
      case (idx)
         5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
         5'd18, 5'd19, 5'd20, 5'd21, 5'd22: r = 1'b1;
         default:                           r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_illegal(input logic [4:0] idx);
      return (idx >= 5'd23);
   endfunction

   function automatic logic [26:0] build_opcode(input logic [IW-1:0] w);
      return {w[3:2], w[1:0], decode_op(w[IW-1 -: 5])};
   endfunction

   assign rdata_idx = bus.imem_rdata[IW-1 -: 5];
   assign ir_idx    = ir[IW-1 -: 5];

   // Memory requests are decoded from state so the first fetch after reset
   // goes out immediately; gated by rst so the bus is idle while in reset.
   always_comb begin
      bus.imem_en   = 1'b0;
      bus.imem_addr = pc;
      case (state)
         FETCH:  bus.imem_en = !rst;
         DECODE: begin
            if (has_imm(rdata_idx)) begin
               bus.imem_en   = 1'b1;
               bus.imem_addr = pc + AW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         imm_q     <= '0;
         opcode_q  <= '0;
         issue_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            FETCH: state <= DECODE;
            DECODE: begin
               ir <= bus.imem_rdata;
               if (has_imm(rdata_idx)) begin
                  state <= IMM;
               end else begin
                  imm_q     <= '0;
                  state     <= ISSUE;
                  issue_q   <= 1'b1;
                  opcode_q  <= build_opcode(bus.imem_rdata);
                  illegal_q <= is_illegal(rdata_idx);
               end
            end
            IMM: begin
               imm_q     <= bus.imem_rdata[DW-1:0];
               state     <= ISSUE;
               issue_q   <= 1'b1;
               opcode_q  <= build_opcode(ir);
               illegal_q <= is_illegal(ir_idx);
            end
            ISSUE: begin
               // illegal is a single-cycle pulse even if the issue is stalled
               illegal_q <= 1'b0;
               if (!bus.stall) begin
                  issue_q  <= 1'b0;
                  opcode_q <= '0;
                  state    <= FETCH;
                  if (bus.pc_we) begin
                     if (bus.pc_mux)
                        pc <= AW'(imm_q);
                     else
                        pc <= pc + (has_imm(ir_idx) ? AW'(2) : AW'(1));
                  end
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.opcode      = opcode_q;
   assign bus.imm         = imm_q;
   assign bus.issue_valid = issue_q;
   assign bus.pc_out      = pc;
   assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed scoreboard bench for instr_fetch_decode: expected issue records are
// queued as each instruction is set up and checked when the DUT issues it.
module tb_instr_fetch_decode;

   typedef struct {
      logic [26:0] opcode;
      logic [7:0]  imm;
      logic [7:0]  pc;
      logic        illegal;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] mem [256];
   exp_t       sbq[$];
   int         n_cmp = 0;
   int         n_mis = 0;

   instr_fetch_decode_if bus ();

   instr_fetch_decode dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [26:0] op, input logic [7:0] imm, input logic [7:0] pc,
                       input logic ill);
      exp_t e;
      e.opcode = op; e.imm = imm; e.pc = pc; e.illegal = ill;
      sbq.push_back(e);
   endtask

   task automatic set_ctl(input logic we, input logic mux);
      bus.pc_we  = we;
      bus.pc_mux = mux;
   endtask

   // Waits (bounded) for issue_valid, then pops and compares one record.
   // dec_en/dec_addr capture the memory request seen during the DECODE cycle.
   task automatic wait_issue(input string tag, output int cyc, output logic dec_en,
                             output logic [7:0] dec_addr);
      exp_t e;
      cyc = 0; dec_en = 1'b0; dec_addr = '0;
      while (!bus.issue_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            dec_en   = bus.imem_en;
            dec_addr = bus.imem_addr;
         end
      end
      if (!bus.issue_valid) begin
         check({tag, "_issue_timeout"}, 32'(bus.issue_valid), 32'd1);
      end else if (sbq.size() == 0) begin
         check({tag, "_sb_underflow"}, 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         check({tag, "_opcode"},  32'(bus.opcode),  32'(e.opcode));
         check({tag, "_imm"},     32'(bus.imm),     32'(e.imm));
         check({tag, "_pc_out"},  32'(bus.pc_out),  32'(e.pc));
         check({tag, "_illegal"}, 32'(bus.illegal), 32'(e.illegal));
      end
   endtask

   task automatic next_fetch(input string tag, input logic [7:0] addr);
      @(negedge clk);
      check({tag, "_fetch_en"},   32'(bus.imem_en),     32'd1);
      check({tag, "_fetch_addr"}, 32'(bus.imem_addr),   32'(addr));
      check({tag, "_valid_off"},  32'(bus.issue_valid), 32'd0);
   endtask

   initial begin
      int          cyc;
      logic        den;
      logic [7:0]  dadr;
      logic [26:0] op_hold;
      logic [7:0]  imm_hold;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h00] = {5'd7, 2'd1, 2'd2};   // ADD
      mem[8'h01] = {5'd18, 2'd0, 2'd0};  // JUMP
      mem[8'h02] = 9'h004;
      mem[8'h04] = {5'd8, 2'd3, 2'd0};   // ADDI
      mem[8'h05] = 9'h0A5;
      mem[8'h06] = {5'd18, 2'd0, 2'd0};
      mem[8'h07] = 9'h010;
      mem[8'h10] = {5'd18, 2'd1, 2'd1};
      mem[8'h11] = 9'h040;
      mem[8'h40] = {5'd18, 2'd0, 2'd0};
      mem[8'h41] = 9'h010;
      mem[8'h12] = {5'd10, 2'd2, 2'd1};
      mem[8'h13] = 9'h03C;
      mem[8'h14] = {5'd18, 2'd0, 2'd0};
      mem[8'h15] = 9'h0FF;
      mem[8'hFF] = {5'd3, 2'd0, 2'd0};

      bus.stall = 1'b0;
      set_ctl(1'b1, 1'b0);

      repeat (3) @(negedge clk);
      check("rst_imem_en",     32'(bus.imem_en),     32'd0);
      check("rst_imem_addr",   32'(bus.imem_addr),   32'd0);
      check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
      check("rst_opcode",      32'(bus.opcode),      32'd0);
      check("rst_imm",         32'(bus.imm),         32'd0);
      check("rst_illegal",     32'(bus.illegal),     32'd0);
      check("rst_pc_out",      32'(bus.pc_out),      32'd0);

      rst = 1'b0;
      #1;
      check("first_fetch_en",   32'(bus.imem_en),   32'd1);
      check("first_fetch_addr", 32'(bus.imem_addr), 32'd0);

      // ADD at 0, sequential advance
      push({2'b01, 2'b10, 23'h000040}, 8'h00, 8'h00, 1'b0);
      wait_issue("add", cyc, den, dadr);
      check("add_latency", 32'(cyc), 32'd2);
      next_fetch("add_next", 8'h01);

      // JUMP at 1 to 4
      set_ctl(1'b1, 1'b1);
      push({2'b00, 2'b00, 23'h020000}, 8'h04, 8'h01, 1'b0);
      wait_issue("jmp1", cyc, den, dadr);
      check("jmp1_imm_addr", 32'(dadr), 32'h02);
      next_fetch("jmp1_next", 8'h04);

      // ADDI at 4: immediate fetched from 5, pc advances by 2
      set_ctl(1'b1, 1'b0);
      push({2'b11, 2'b00, 23'h000080}, 8'hA5, 8'h04, 1'b0);
      wait_issue("addi", cyc, den, dadr);
      check("addi_latency",  32'(cyc), 32'd3);
      check("addi_imm_en",   32'(den), 32'd1);
      check("addi_imm_addr", 32'(dadr), 32'h05);
      next_fetch("addi_next", 8'h06);

      set_ctl(1'b1, 1'b1);
      push({2'b00, 2'b00, 23'h020000}, 8'h10, 8'h06, 1'b0);
      wait_issue("jmp6", cyc, den, dadr);
      next_fetch("jmp6_next", 8'h10);

      // JUMP at 0x10: pc_we = 0 re-executes, then taken, then not taken
      set_ctl(1'b0, 1'b1);
      push({2'b01, 2'b01, 23'h020000}, 8'h40, 8'h10, 1'b0);
      wait_issue("jmp10_hold", cyc, den, dadr);
      next_fetch("jmp10_hold_next", 8'h10);

      set_ctl(1'b1, 1'b1);
      push({2'b01, 2'b01, 23'h020000}, 8'h40, 8'h10, 1'b0);
      wait_issue("jmp10_taken", cyc, den, dadr);
      next_fetch("jmp10_taken_next", 8'h40);

      push({2'b00, 2'b00, 23'h020000}, 8'h10, 8'h40, 1'b0);
      wait_issue("jmp40", cyc, den, dadr);
      next_fetch("jmp40_next", 8'h10);

      set_ctl(1'b1, 1'b0);
      push({2'b01, 2'b01, 23'h020000}, 8'h40, 8'h10, 1'b0);
      wait_issue("jmp10_seq", cyc, den, dadr);
      next_fetch("jmp10_seq_next", 8'h12);

      // stall held through issue while pc_mux toggles
      bus.stall = 1'b1;
      set_ctl(1'b1, 1'b1);
      push({2'b10, 2'b01, 23'h000200}, 8'h3C, 8'h12, 1'b0);
      wait_issue("stall", cyc, den, dadr);
      op_hold  = bus.opcode;
      imm_hold = bus.imm;
      for (int i = 0; i < 5; i++) begin
         bus.pc_mux = ~bus.pc_mux;
         @(negedge clk);
         check($sformatf("stall%0d_valid", i),  32'(bus.issue_valid), 32'd1);
         check($sformatf("stall%0d_en", i),     32'(bus.imem_en),     32'd0);
         check($sformatf("stall%0d_opcode", i), 32'(bus.opcode),      32'(op_hold));
         check($sformatf("stall%0d_imm", i),    32'(bus.imm),         32'(imm_hold));
         check($sformatf("stall%0d_pc", i),     32'(bus.pc_out),      32'h12);
      end
      bus.stall = 1'b0;
      set_ctl(1'b1, 1'b0);
      next_fetch("stall_release", 8'h14);

      set_ctl(1'b1, 1'b1);
      push({2'b00, 2'b00, 23'h020000}, 8'hFF, 8'h14, 1'b0);
      wait_issue("jmp14", cyc, den, dadr);
      next_fetch("jmp14_next", 8'hFF);

      // memory rewrites below only touch words already consumed
      mem[8'h00] = {5'd18, 2'd0, 2'd0};
      mem[8'h01] = 9'h0FF;

      // single-word at 0xFF wraps to 0x00
      set_ctl(1'b1, 1'b0);
      push({2'b00, 2'b00, 23'h000004}, 8'h00, 8'hFF, 1'b0);
      wait_issue("wrap1", cyc, den, dadr);
      next_fetch("wrap1_next", 8'h00);
      mem[8'hFF] = {5'd11, 2'd1, 2'd3};

      set_ctl(1'b1, 1'b1);
      push({2'b00, 2'b00, 23'h020000}, 8'hFF, 8'h00, 1'b0);
      wait_issue("jmp0", cyc, den, dadr);
      next_fetch("jmp0_next", 8'hFF);
      mem[8'h00] = 9'h1C3;
      mem[8'h01] = {5'd25, 2'd2, 2'd3};
      mem[8'h02] = {5'd4, 2'd0, 2'd0};
      mem[8'h03] = 9'h055;

      // immediate-carrying at 0xFF: immediate read from 0x00, next pc 0x01
      set_ctl(1'b1, 1'b0);
      push({2'b01, 2'b11, 23'h000400}, 8'hC3, 8'hFF, 1'b0);
      wait_issue("wrap2", cyc, den, dadr);
      check("wrap2_imm_addr", 32'(dadr), 32'h00);
      next_fetch("wrap2_next", 8'h01);

      // undefined index 25
      push({2'b10, 2'b11, 23'h000000}, 8'h00, 8'h01, 1'b1);
      wait_issue("illegal", cyc, den, dadr);
      next_fetch("illegal_next", 8'h02);
      check("illegal_pulse_end", 32'(bus.illegal), 32'd0);

      // reset asserted in the IMM cycle
      @(negedge clk);
      check("imm4_fetch_addr", 32'(bus.imem_addr), 32'h03);
      @(negedge clk);
      check("mid_imm_pc", 32'(bus.pc_out), 32'h02);
      rst = 1'b1;
      #1;
      check("rst2_imem_en",   32'(bus.imem_en),     32'd0);
      check("rst2_imem_addr", 32'(bus.imem_addr),   32'd0);
      check("rst2_valid",     32'(bus.issue_valid), 32'd0);
      check("rst2_opcode",    32'(bus.opcode),      32'd0);
      check("rst2_pc_out",    32'(bus.pc_out),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst2_fetch_en",   32'(bus.imem_en),   32'd1);
      check("rst2_fetch_addr", 32'(bus.imem_addr), 32'd0);

      set_ctl(1'b0, 1'b0);
      push({2'b00, 2'b11, 23'h000000}, 8'h00, 8'h00, 1'b1);
      wait_issue("post_rst", cyc, den, dadr);
      check("post_rst_latency", 32'(cyc), 32'd2);
      check("sb_leftover", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front-end stage directly upstream of the control unit.
- Fetches instruction words from instruction memory and decodes each word into the 27-bit opcode bundle {x, y, one-hot op} that the control unit consumes.
- Fetches a trailing immediate word when the opcode requires one.
- Owns the PC and applies the control unit's pc_mux/pc_we decision at the issue cycle.

Parameters:
- AW, 8, instruction-memory address / PC width.
- IW, 9, instruction word width: [8:4] opcode index, [3:2] x, [1:0] y.
- DW, 8, immediate width; taken from the low DW bits of the immediate word.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- imem_en  out  1  instruction memory read enable.
- imem_addr  out  AW  instruction memory read address.
- imem_rdata  in  IW  read data, valid the cycle after imem_en.
- stall  in  1  holds the issue slot; downstream not ready.
- pc_mux  in  1  from control unit; 1 = branch/jump to immediate.
- pc_we  in  1  from control unit; 1 = PC advances this issue.
- opcode  out  27  {x[26:25], y[24:23], op[22:0]} to the control unit.
- imm  out  DW  immediate of the issued instruction; 0 if none.
- issue_valid  out  1  opcode/imm are the live instruction this cycle.
- pc_out  out  AW  address of the instruction currently held.
- illegal  out  1  one-cycle pulse at issue of an undefined opcode index.

Behaviour:
- Reset (async, any state) forces:
  - State FETCH; pc = RESET_PC; IR = 0; imm = 0; opcode = 0; issue_valid = 0; illegal = 0.
  - imem_en = 0 and imem_addr = RESET_PC while rst is high.
- Decode mapping:
  - Index k in 1..22 sets op[k-1] only; index 0 (NOOP) gives op = 0.
  - Indices 23..31 decode as NOOP (op = 0) and assert illegal during the issue cycle.
  - op[22] is always 0.
  - x and y pass through from IR[3:2] and IR[1:0].
- Immediate-carrying indices: 2, 4, 6, 8, 10, 11, 12, 13, 14, 18, 19, 20, 21, 22. All other indices are single-word.
- FSM states and transitions:
  - FETCH: imem_en = 1, imem_addr = pc → DECODE.
  - DECODE: latch IR from imem_rdata.
    - Immediate-carrying index: imem_en = 1, imem_addr = pc+1 → IMM.
    - Otherwise: imm = 0 → ISSUE.
  - IMM: latch imm from imem_rdata[DW-1:0] → ISSUE.
  - ISSUE: issue_valid = 1 and opcode = decode(IR).
    - stall = 1: stay in ISSUE; all outputs held stable; pc_mux and pc_we are ignored.
    - stall = 0: apply the PC update below, then → FETCH.
- PC update at the ISSUE exit cycle:
  - pc_we = 0: pc unchanged (re-executes the same instruction).
  - pc_we = 1, pc_mux = 1: pc = imm[AW-1:0], zero-extended if DW < AW.
  - pc_we = 1, pc_mux = 0: pc = pc + len, where len = 2 for immediate-carrying instructions and 1 otherwise.
- Arithmetic: all PC arithmetic is modulo 2^AW. The immediate-fetch address pc+1 also wraps.
- Outside ISSUE: opcode = 0 and issue_valid = 0, so the control unit sees NOOP.
- Latency:
  - Single-word instruction: issue on the 3rd cycle after entering FETCH; 3 cycles per instruction with no stall.
  - Immediate-carrying instruction: 4 cycles per instruction.
- pc_out equals the PC of the instruction in IR and is stable throughout DECODE, IMM and ISSUE.

Test Plan:
- Reset, then rst released with mem[0] = {5'd7, 2'd1, 2'd2} (ADD) → issue_valid at cycle 3; opcode = {2'b01, 2'b10, 23'h40}; imm = 0; with pc_we = 1, pc_mux = 0, next fetch address = 1.
- mem[4] = {5'd8, x = 3}, mem[5] = 9'h0A5 (ADDI) → IMM fetch at address 5; issue with imm = 8'hA5, op[7] = 1; pc → 6.
- JUMP (index 18) at pc 0x10 with imm 0x40, pc_mux = 1, pc_we = 1 → next imem_addr = 0x40. Same instruction with pc_mux = 0 → next imem_addr = 0x12.
- stall held high for 5 cycles during ISSUE while pc_mux toggles → opcode, imm and pc_out constant; no fetch issued; PC update applied only on the first stall = 0 cycle.
- Single-word instruction at pc = 0xFF → next pc = 0x00. Immediate-carrying instruction at pc = 0xFF → immediate read from 0x00, next pc = 0x01.
- Index 25 fetched → opcode op = 0, illegal = 1 for exactly one issue cycle. Then rst asserted mid-IMM → all outputs cleared immediately; first fetch after release at RESET_PC.
